// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared glyph, pattern and FSM definitions for the seven-segment driver
package seven_segment_pkg;

    typedef enum logic [3:0] {
        G_0, G_1, G_2, G_3, G_4, G_5, G_6, G_7, G_8, G_9, G_BLANK, G_DASH
    } glyph_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    function automatic logic [39:0] pow10(input int n);
        logic [39:0] r;
        r = 40'd1;
        for (int i = 0; i < 10; i++) begin
            if (i < n) r = r * 40'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_glyph_encoder.sv
// rtl/seg7_glyph_encoder.sv - glyph to seven-segment pattern with selectable output polarity
module seg7_glyph_encoder
    import seven_segment_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  glyph_t     glyph,
    output logic [6:0] segments
);

    logic [6:0] pattern;

    always_comb begin
        pattern = SEG_BLANK;
        case (glyph)
            G_0:     pattern = SEG_0;
            G_1:     pattern = SEG_1;
            G_2:     pattern = SEG_2;
            G_3:     pattern = SEG_3;
            G_4:     pattern = SEG_4;
            G_5:     pattern = SEG_5;
            G_6:     pattern = SEG_6;
            G_7:     pattern = SEG_7;
            G_8:     pattern = SEG_8;
            G_9:     pattern = SEG_9;
            G_DASH:  pattern = SEG_DASH;
            default: pattern = SEG_BLANK;
        endcase
        segments = ACTIVE_LOW ? ~pattern : pattern;
    end

endmodule

// File: rtl/seven_segment_bcd_driver.sv
// rtl/seven_segment_bcd_driver.sv - sequential double-dabble binary to BCD seven-segment display driver
module seven_segment_bcd_driver
    import seven_segment_pkg::*;
#(
    parameter int VALUE_WIDTH   = 20,
    parameter int DIGITS        = 6,
    parameter bit BLANK_LEADING = 1'b1,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                         clock_50Mhz,
    input  logic                         reset_n,
    input  logic                         update_valid,
    input  logic [VALUE_WIDTH-1:0]       value_in,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [DIGITS-1:0][6:0]       segments
);

    localparam int          BCD_W = 4 * DIGITS;
    localparam int          CNT_W = $clog2(VALUE_WIDTH + 1);
    localparam logic [39:0] LIMIT = pow10(DIGITS);

    if (DIGITS > 9 || DIGITS < 1 || VALUE_WIDTH > 32) begin : g_param_check
        $error("seven_segment_bcd_driver: DIGITS must be 1..9 and VALUE_WIDTH <= 32");
    end

    state_t                 state, state_next;
    logic [VALUE_WIDTH-1:0] bin_q, bin_sh, pend_data_q, start_value;
    logic [BCD_W-1:0]       bcd_q, bcd_adj, bcd_sh;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovf_q, pend_valid_q, start;
    glyph_t                 disp_q    [DIGITS];
    glyph_t                 disp_next [DIGITS];

    // A request in COMMIT supersedes any older pending value (latest wins).
    always_comb begin
        start       = 1'b0;
        start_value = value_in;
        case (state)
            S_IDLE:   start = update_valid;
            S_COMMIT: begin
                start       = update_valid | pend_valid_q;
                start_value = update_valid ? value_in : pend_data_q;
            end
            default:  start = 1'b0;
        endcase
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (update_valid) state_next = S_SHIFT;
            S_SHIFT:  if (cnt_q == CNT_W'(1)) state_next = S_COMMIT;
            S_COMMIT: state_next = start ? S_SHIFT : S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
        end
        {bcd_sh, bin_sh} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
    end

    // Overflow is decided at capture; a carry out of the top nibble is the same condition seen from the BCD side.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (start) begin
            bin_q <= start_value;
            bcd_q <= '0;
            cnt_q <= CNT_W'(VALUE_WIDTH);
            ovf_q <= (40'(start_value) >= LIMIT);
        end else if (state == S_SHIFT) begin
            bin_q <= bin_sh;
            bcd_q <= bcd_sh;
            cnt_q <= cnt_q - 1'b1;
            ovf_q <= ovf_q | bcd_adj[BCD_W-1];
        end
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
        end else if (state == S_COMMIT) begin
            pend_valid_q <= 1'b0;
        end else if (state == S_SHIFT && update_valid) begin
            pend_valid_q <= 1'b1;
            pend_data_q  <= value_in;
        end
    end

    always_comb begin
        logic       seen;
        logic [3:0] nib;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = bcd_q[i*4 +: 4];
            if (nib != 4'd0) seen = 1'b1;
            if (ovf_q)                                    disp_next[i] = G_DASH;
            else if (BLANK_LEADING && !seen && i != 0)    disp_next[i] = G_BLANK;
            else                                          disp_next[i] = glyph_t'(nib);
        end
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            done     <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < DIGITS; i++) disp_q[i] <= G_BLANK;
        end else begin
            done <= (state == S_COMMIT);
            if (state == S_COMMIT) begin
                overflow <= ovf_q;
                for (int i = 0; i < DIGITS; i++) disp_q[i] <= disp_next[i];
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_glyph_encoder #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc (
            .glyph    (disp_q[g]),
            .segments (segments[g])
        );
    end

endmodule

// File: tb/tb_seven_segment_bcd_driver.sv
// tb/tb_seven_segment_bcd_driver.sv - directed self-checking bench for seven_segment_bcd_driver
module tb_seven_segment_bcd_driver;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             update_valid;
    logic [19:0]      value_in;
    logic             busy0, done0, ovf0;
    logic             busy1, done1, ovf1;
    logic             busy2, done2, ovf2;
    logic [5:0][6:0]  seg0, seg1, seg2;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int n;
    int snap;
    bit saw22 = 1'b0;

    always #5 clk = ~clk;

    seven_segment_bcd_driver #(.VALUE_WIDTH(20), .DIGITS(6), .BLANK_LEADING(1'b1), .ACTIVE_LOW(1'b1)) dut0 (
        .clock_50Mhz(clk), .reset_n(reset_n), .update_valid(update_valid), .value_in(value_in),
        .busy(busy0), .done(done0), .overflow(ovf0), .segments(seg0));

    seven_segment_bcd_driver #(.VALUE_WIDTH(20), .DIGITS(6), .BLANK_LEADING(1'b0), .ACTIVE_LOW(1'b1)) dut1 (
        .clock_50Mhz(clk), .reset_n(reset_n), .update_valid(update_valid), .value_in(value_in),
        .busy(busy1), .done(done1), .overflow(ovf1), .segments(seg1));

    seven_segment_bcd_driver #(.VALUE_WIDTH(20), .DIGITS(6), .BLANK_LEADING(1'b1), .ACTIVE_LOW(1'b0)) dut2 (
        .clock_50Mhz(clk), .reset_n(reset_n), .update_valid(update_valid), .value_in(value_in),
        .busy(busy2), .done(done2), .overflow(ovf2), .segments(seg2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] pat(input byte c);
        case (c)
            "0": return 7'h3F;
            "1": return 7'h06;
            "2": return 7'h5B;
            "3": return 7'h4F;
            "4": return 7'h66;
            "5": return 7'h6D;
            "6": return 7'h7D;
            "7": return 7'h07;
            "8": return 7'h7F;
            "9": return 7'h6F;
            "-": return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    // s[0] is the most-significant digit
    function automatic logic [41:0] disp(input string s, input bit active_low);
        logic [41:0] v;
        for (int i = 0; i < 6; i++) v[i*7 +: 7] = pat(s[5-i]);
        return active_low ? ~v : v;
    endfunction

    task automatic send(input logic [19:0] v);
        @(negedge clk);
        update_valid = 1'b1;
        value_in     = v;
        @(negedge clk);
        update_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done0 && cyc < 60);
    endtask

    task automatic expect_display(input string tag, input int lat, input string s, input logic ovf);
        int c;
        wait_done(c);
        check({tag, "/latency"}, c, lat);
        check({tag, "/segments"}, seg0, disp(s, 1'b1));
        check({tag, "/overflow"}, ovf0, ovf);
    endtask

    always @(negedge clk) begin
        if (done0) done_cnt++;
        if (seg0 == disp("    22", 1'b1)) saw22 = 1'b1;
    end

    initial begin
        reset_n      = 1'b0;
        update_valid = 1'b0;
        value_in     = '0;
        repeat (3) @(negedge clk);
        check("reset/seg_al", seg0, {42{1'b1}});
        check("reset/seg_ah", seg2, 42'h0);
        check("reset/busy", busy0, 1'b0);
        check("reset/done", done0, 1'b0);
        check("reset/overflow", ovf0, 1'b0);
        reset_n = 1'b1;

        send(20'd123456);
        check("123456/busy_early", busy0, 1'b1);
        expect_display("123456", 21, "123456", 1'b0);
        check("123456/busy_after", busy0, 1'b0);

        send(20'd0);
        expect_display("zero", 21, "     0", 1'b0);
        check("zero/noblank", seg1, disp("000000", 1'b1));

        send(20'd907);
        expect_display("907", 21, "   907", 1'b0);
        check("907/noblank", seg1, disp("000907", 1'b1));

        send(20'd999999);
        expect_display("999999", 21, "999999", 1'b0);

        send(20'd1000000);
        expect_display("1000000", 21, "------", 1'b1);
        check("1000000/noblank", seg1, disp("------", 1'b1));
        check("1000000/ovf_noblank", ovf1, 1'b1);

        send(20'd1048575);
        expect_display("1048575", 21, "------", 1'b1);

        send(20'd11);
        send(20'd22);
        send(20'd33);
        expect_display("pend_first", 17, "    11", 1'b0);
        check("pend_first/busy", busy0, 1'b1);
        expect_display("pend_second", 21, "    33", 1'b0);
        check("pend_second/busy", busy0, 1'b0);
        check("pend/never22", saw22, 1'b0);

        send(20'd555555);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset/seg", seg0, {42{1'b1}});
        check("midreset/busy", busy0, 1'b0);
        check("midreset/done", done0, 1'b0);
        snap = done_cnt;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("midreset/no_done", done_cnt, snap);
        check("midreset/idle", busy0, 1'b0);
        check("midreset/still_blank", seg0, {42{1'b1}});

        send(20'd42);
        expect_display("42", 21, "    42", 1'b0);

        send(20'd8);
        expect_display("8", 21, "     8", 1'b0);
        check("8/active_high", seg2, 42'h7F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
